// File: rtl/pixel_cache_if.sv
// Pixel-read and frame-buffer port bundle for the edge_search pixel cache.
// The slave modport is the cache; the master is the requester/memory side.
interface pixel_cache_if #(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 16
);
  logic [9:0]        x;
  logic [9:0]        y;
  logic              request;
  logic              pixel;
  logic              ready;
  logic              invalidate;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rd_data;
  logic              mem_rd_valid;

  modport slave (
    input  x, y, request, invalidate, mem_rd_data, mem_rd_valid,
    output pixel, ready, mem_rd_en, mem_addr
  );

  modport master (
    output x, y, request, invalidate, mem_rd_data, mem_rd_valid,
    input  pixel, ready, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/pixel_cache.sv
// Direct-mapped cache of WORD_W-pixel horizontal words serving single-pixel reads
// for the edge searchers; misses are filled from the 1-bpp frame-buffer port.
module pixel_cache #(
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int WORD_W      = 16,
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 15,
  parameter int REQ_GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  pixel_cache_if.slave      bus,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int WX_W  = 10 - BIT_W;
  localparam int TAG_W = 10 + WX_W;
  localparam int WPR   = FRAME_W / WORD_W;
  localparam int GAP_W = (REQ_GAP > 1) ? $clog2(REQ_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((REQ_GAP > 0) ? REQ_GAP - 1 : 0);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] MISS_REQ  = 3'd2;
  localparam logic [2:0] MISS_WAIT = 3'd3;
  localparam logic [2:0] RESPOND   = 3'd4;
  localparam logic [2:0] HOLDOFF   = 3'd5;

  logic [2:0]              state;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    fill_kill;
  logic [9:0]              x_p0;
  logic [9:0]              y_p0;
  logic [NUM_ENTRIES-1:0]  line_vld;
  logic [TAG_W-1:0]        tag_mem  [NUM_ENTRIES];
  logic [WORD_W-1:0]       data_mem [NUM_ENTRIES];

  logic [WX_W-1:0]         wx;
  logic [BIT_W-1:0]        bsel;
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [ADDR_W-1:0]       addr_calc;
  logic                    in_range;
  logic                    hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lookup stage: decode the latched coordinates against the cache
  assign wx        = x_p0[9:BIT_W];
  assign bsel      = x_p0[BIT_W-1:0];
  assign idx       = IDX_W'(wx) + IDX_W'(y_p0);
  assign tag       = {y_p0, wx};
  assign in_range  = ({22'd0, x_p0} < 32'(FRAME_W)) && ({22'd0, y_p0} < 32'(FRAME_H));
  assign hit       = line_vld[idx] && (tag_mem[idx] == tag);
  assign addr_calc = ADDR_W'(32'(y_p0) * 32'(WPR) + 32'(wx));

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.request) begin
      x_p0 <= bus.x;
      y_p0 <= bus.y;
    end
    if (state == MISS_WAIT && bus.mem_rd_valid) begin
      data_mem[idx] <= bus.mem_rd_data;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      fill_kill     <= 1'b0;
      line_vld      <= '0;
      bus.pixel     <= 1'b0;
      bus.ready     <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      bus.ready     <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      case (state)
        IDLE: if (bus.request) state <= LOOKUP;
        LOOKUP: begin
          if (!in_range) begin
            bus.pixel <= 1'b0;
            bus.ready <= 1'b1;
            state     <= RESPOND;
          end else if (hit) begin
            bus.pixel <= data_mem[idx][bsel];
            bus.ready <= 1'b1;
            hit_count <= sat_inc(hit_count);
            state     <= RESPOND;
          end else begin
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= addr_calc;
            fill_kill     <= 1'b0;
            state         <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          miss_count <= sat_inc(miss_count);
          state      <= MISS_WAIT;
        end
        MISS_WAIT: if (bus.mem_rd_valid) begin
          bus.pixel <= bus.mem_rd_data[bsel];
          bus.ready <= 1'b1;
          state     <= RESPOND;
          if (!bus.invalidate && !fill_kill) line_vld[idx] <= 1'b1;
        end
        RESPOND: begin
          gap_cnt <= '0;
          state   <= (REQ_GAP == 0) ? IDLE : HOLDOFF;
        end
        HOLDOFF: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
      // A new-frame flush wins over any fill landing this cycle, and poisons an in-flight fill
      if (bus.invalidate) begin
        line_vld <= '0;
        if (state == MISS_REQ || state == MISS_WAIT) fill_kill <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pixel_cache.sv
// Bench for pixel_cache: table of pixel requests plus hand sequences for holdoff,
// invalidate and reset-during-miss, with a scoreboard of expected ready pulses.
module tb_pixel_cache;
  localparam int REQ_GAP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  pixel_cache_if #(.ADDR_W(15), .WORD_W(16)) bus ();

  pixel_cache #(
    .FRAME_W(640), .FRAME_H(480), .WORD_W(16), .NUM_ENTRIES(16),
    .ADDR_W(15), .REQ_GAP(REQ_GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic pix; int cyc; } exp_t;
  typedef struct { int x; int y; int kind; int eh; int em; } vec_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   rd_cnt = 0;
  int   rdy_cnt = 0;
  int   last_addr = -1;
  int   mem_lat = 3;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] mem_word(input int a);
    if (a == 0) return 16'h0020;
    return 16'((a * 40503) ^ (a << 7) ^ 16'h3C96);
  endfunction

  function automatic logic pixel_of(input int xx, input int yy);
    logic [15:0] w;
    if (xx >= 640 || yy >= 480) return 1'b0;
    w = mem_word(yy * 40 + xx / 16);
    return w[xx % 16];
  endfunction

  // Frame-buffer model: answers each strobe after mem_lat cycles
  initial begin
    int a;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        a = int'(bus.mem_addr);
        last_addr = a;
        repeat (mem_lat) @(negedge clk);
        bus.mem_rd_data  = mem_word(a);
        bus.mem_rd_valid = 1'b1;
        @(negedge clk);
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
      end
    end
  end

  // Scoreboard monitor: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.ready) begin
      rdy_cnt++;
      check("ready_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel", 32'(bus.pixel), 32'(e.pix));
        check("ready_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_req(input int xx, input int yy, input int kind, input bit inv,
                        input int eh, input int em);
    int   rd0;
    int   t;
    exp_t e;
    rd0 = rd_cnt;
    bus.x = 10'(xx);
    bus.y = 10'(yy);
    bus.request = 1'b1;
    e.pix = pixel_of(xx, yy);
    e.cyc = cyc + ((kind == 1) ? 3 + mem_lat : 2);
    exp_q.push_back(e);
    @(negedge clk);
    bus.request = 1'b0;
    if (inv) begin
      t = 0;
      while (!bus.mem_rd_en && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      bus.invalidate = 1'b1;
      @(negedge clk);
      bus.invalidate = 1'b0;
    end
    t = 0;
    while (!bus.ready && t < 60) begin @(negedge clk); t++; end
    check("ready_seen", 32'(bus.ready), 1);
    check("hit_count", 32'(hit_count), eh);
    check("miss_count", 32'(miss_count), em);
    check("rd_strobes", rd_cnt - rd0, (kind == 1) ? 1 : 0);
    if (kind == 1) check("mem_addr", last_addr, yy * 40 + xx / 16);
    repeat (REQ_GAP + 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    int   n, rd0, rdy0, t;

    // kind: 0 hit, 1 miss, 2 out of range
    vecs[0]  = '{5,   0,   1, 0, 1};
    vecs[1]  = '{6,   0,   0, 1, 1};
    vecs[2]  = '{700, 3,   2, 1, 1};
    vecs[3]  = '{100, 479, 1, 1, 2};
    vecs[4]  = '{101, 479, 0, 2, 2};
    vecs[5]  = '{0,   16,  1, 2, 3};
    vecs[6]  = '{5,   0,   1, 2, 4};
    vecs[7]  = '{639, 0,   1, 2, 5};
    vecs[8]  = '{5,   480, 2, 2, 5};
    vecs[9]  = '{15,  0,   0, 3, 5};
    vecs[10] = '{639, 0,   0, 4, 5};

    reset = 1'b1;
    bus.x = '0;
    bus.y = '0;
    bus.request = 1'b0;
    bus.invalidate = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pixel", 32'(bus.pixel), 0);
    check("rst_ready", 32'(bus.ready), 0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_hits", 32'(hit_count), 0);
    check("rst_misses", 32'(miss_count), 0);
    reset = 1'b0;
    @(negedge clk);

    check("pixel_model_word0", 32'(pixel_of(5, 0)), 1);
    foreach (vecs[i]) do_req(vecs[i].x, vecs[i].y, vecs[i].kind, 1'b0, vecs[i].eh, vecs[i].em);

    // Request held high; coordinates change two cycles after each ready
    rd0  = rd_cnt;
    rdy0 = rdy_cnt;
    n    = cyc;
    bus.x = 10'd7;
    bus.y = 10'd0;
    bus.request = 1'b1;
    exp_q.push_back('{pixel_of(7, 0), n + 2});
    exp_q.push_back('{pixel_of(100, 479), n + 7});
    exp_q.push_back('{1'b0, n + 12});
    while (cyc < n + 4)  @(negedge clk);
    bus.x = 10'd100;
    bus.y = 10'd479;
    while (cyc < n + 9)  @(negedge clk);
    bus.x = 10'd700;
    bus.y = 10'd3;
    while (cyc < n + 13) @(negedge clk);
    bus.request = 1'b0;
    repeat (4) @(negedge clk);
    check("held_ready_count", rdy_cnt - rdy0, 3);
    check("held_rd_strobes", rd_cnt - rd0, 0);
    check("held_hits", 32'(hit_count), 6);

    // Invalidate between requests, then invalidate while a fill is pending
    do_req(5, 0, 0, 1'b0, 7, 5);
    bus.invalidate = 1'b1;
    @(negedge clk);
    bus.invalidate = 1'b0;
    @(negedge clk);
    do_req(5, 0, 1, 1'b0, 7, 6);
    mem_lat = 4;
    do_req(100, 479, 1, 1'b1, 7, 7);
    mem_lat = 3;
    do_req(100, 479, 1, 1'b0, 7, 8);
    do_req(5, 0, 1, 1'b0, 7, 9);

    // Reset while waiting on memory; the late read data must be ignored
    mem_lat = 5;
    rdy0 = rdy_cnt;
    bus.x = 10'd50;
    bus.y = 10'd2;
    bus.request = 1'b1;
    @(negedge clk);
    bus.request = 1'b0;
    t = 0;
    while (!bus.mem_rd_en && t < 20) begin @(negedge clk); t++; end
    check("abandon_rd_en", 32'(bus.mem_rd_en), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abandon_no_ready", rdy_cnt - rdy0, 0);
    check("abandon_misses", 32'(miss_count), 0);
    check("abandon_hits", 32'(hit_count), 0);
    check("abandon_addr", 32'(bus.mem_addr), 0);
    check("abandon_pixel", 32'(bus.pixel), 0);
    mem_lat = 3;
    do_req(16, 1, 1, 1'b0, 0, 1);
    check("addr_16_1", last_addr, 41);
    do_req(17, 1, 0, 1'b0, 1, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
